mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller for the 5-stage MIPS pipeline. Takes the EX2MEM outputs, runs loads and stores over a req/ack data-memory port, freezes the upstream stages while an access is in flight, and drives the inputs of MEM2WB. Non-memory instructions pass through with no added latency. A watchdog bounds every access.

## Interface
Parameters:
- REG_FILE_ADDR_LEN, 5: destination register address width.
- TIMEOUT, 255: WAIT cycles without ack before abort; 1..255.
- ERR_DATA, 32'hDEAD_BEEF: memReadVal returned on an aborted load.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  input  1 each  EX2MEM control.
- ALUResIn  input  32  ALU result / memory byte address.
- STValIn  input  32  store data.
- destIn  input  REG_FILE_ADDR_LEN  destination register.
- mem_req  output  1  access request, held until ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr, mem_wdata  output  32 each  word address / store data.
- mem_ack  input  1  access complete; mem_rdata valid the same cycle.
- mem_rdata  input  32  read data.
- WB_EN, MEM_R_EN  output  1 each  to MEM2WB.
- ALURes, memReadVal  output  32 each  to MEM2WB.
- dest  output  REG_FILE_ADDR_LEN  to MEM2WB.
- freeze  output  1  hold PC, IF2ID, ID2EX and EX2MEM.
- mem_err  output  1  sticky: an access timed out.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state: IDLE.
- IDLE with no memory instruction (MEM_R_EN_IN=0 and MEM_W_EN_IN=0):
  - Outputs to MEM2WB combinationally equal the inputs.
  - memReadVal=0 and freeze=0.
- IDLE with MEM_R_EN_IN or MEM_W_EN_IN set:
  - Latch WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALUResIn, STValIn and destIn into holding registers.
  - freeze=1. Outputs to MEM2WB are a bubble: WB_EN=0, MEM_R_EN=0, ALURes=0, dest=0.
  - Next state WAIT.
  - If both R and W are set, the read wins and the write is dropped.
- WAIT:
  - mem_req=1. mem_we is the latched W. mem_addr is {latched address[31:2], 2'b00}. mem_wdata is the latched store data.
  - freeze=1; MEM2WB outputs are a bubble.
  - On mem_ack: capture mem_rdata (reads only) and go to DONE.
  - Watchdog counter, 8 bits: cleared on entry to WAIT, incremented each WAIT cycle without ack.
  - On reaching TIMEOUT: go to DONE, set mem_err, load result = ERR_DATA. ack and timeout in the same cycle: ack wins.
- DONE:
  - Drive latched WB_EN, MEM_R_EN, ALURes and dest; memReadVal = captured data (0 for stores).
  - freeze=0. mem_req=0. EX2MEM inputs are ignored, because they still hold the just-finished instruction.
  - Next state IDLE.
- mem_err clears only on reset.
- Between accesses mem_addr and mem_wdata keep their last value; their value is don't-care while mem_req=0.
- mem_ack outside WAIT is ignored.

## Timing
- Non-memory instruction: 0 added cycles.
- Load or store with ack in the first WAIT cycle: 3 cycles in MEM (IDLE, WAIT, DONE); freeze high for 2 cycles.
- Each extra wait-state adds 1 cycle.
- mem_req rises one cycle after the memory instruction appears and falls in the cycle after ack.
- mem_req is a registered state decode; it is glitch-free.
- freeze is combinational from state and inputs; the upstream registers sample it at the same edge.
- Reset values while rst=0: state IDLE, mem_req=0, mem_we=0, freeze=0, mem_err=0, and all holding registers, counter, mem_addr, mem_wdata and captured data = 0. Outputs to MEM2WB show the IDLE pass-through of the current inputs.
- Reset mid-access: mem_req drops asynchronously and the access is abandoned. Memory must tolerate a withdrawn request.

## Structure
- The shared package holds REG_FILE_ADDR_LEN, the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the ERR_DATA default.
- One sub-module, mem_wdog: the 8-bit watchdog, with clear, count enable and timeout compare. Parameter is TIMEOUT.
- The FSM, holding registers and output muxing stay in mem_stage_ctrl.

## Test plan
- ADD passes through with WB_EN_IN=1, ALUResIn=32'h10, destIn=5 -> same cycle WB_EN=1, ALURes=32'h10, dest=5, freeze=0, mem_req=0.
- LW with address 32'h0000_0046, ack after 2 wait-states, rdata=32'h1234_5678 -> mem_addr=32'h44; freeze high for 4 cycles; DONE shows WB_EN=1, MEM_R_EN=1, memReadVal=32'h1234_5678, dest=destIn.
- SW with STValIn=32'hCAFE_F00D, immediate ack -> mem_we=1, mem_wdata=32'hCAFE_F00D; DONE shows WB_EN=0 and memReadVal=0; freeze high for 2 cycles.
- LW with no ack and TIMEOUT=4 -> DONE after the 4th WAIT cycle; memReadVal=32'hDEAD_BEEF; mem_err=1 and stays 1.
- Back-to-back LW then SW -> the SW is latched only after DONE; no overlap of mem_req; each completes with the correct data.
- rst asserted in WAIT -> mem_req=0 and freeze=0 immediately; after release the state is IDLE and a late ack is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared constants and FSM encoding for the MEM-stage controller.
package mem_stage_ctrl_pkg;
  localparam int          DEF_REG_FILE_ADDR_LEN = 5;
  localparam logic [31:0] DEF_ERR_DATA          = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mem_wdog.sv
// Access watchdog: counts WAIT cycles without ack, flags timeout in the cycle the count reaches TIMEOUT.
// Zero latency on the timeout flag; no backpressure.
module mem_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Counting this cycle would bring the total to TIMEOUT.
  assign timeout = en & ~clr & (cnt_q == LAST);
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: passes ALU ops through in 0 cycles, runs loads/stores over req/ack (>=3 cycles).
// Backpressure: freeze holds the upstream stages while an access is latched or in flight.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int          REG_FILE_ADDR_LEN = DEF_REG_FILE_ADDR_LEN,
  parameter int unsigned TIMEOUT           = 255,
  parameter logic [31:0] ERR_DATA          = DEF_ERR_DATA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN_IN,
  input  logic                         MEM_R_EN_IN,
  input  logic                         MEM_W_EN_IN,
  input  logic [31:0]                  ALUResIn,
  input  logic [31:0]                  STValIn,
  input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata,
  output logic                         WB_EN,
  output logic                         MEM_R_EN,
  output logic [31:0]                  ALURes,
  output logic [31:0]                  memReadVal,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic                         freeze,
  output logic                         mem_err
);
  state_e                       state_q, state_d;
  logic                         wb_q, wb_d, rd_q, rd_d, we_q, we_d;
  logic                         req_q, req_d, err_q, err_d;
  logic [31:0]                  addr_q, addr_d, st_q, st_d, rdat_q, rdat_d;
  logic [REG_FILE_ADDR_LEN-1:0] dst_q, dst_d;
  logic                         idle_mem, pass, done, wd_to;

  // Gated by reset so the stage reads as a plain pass-through while held in reset.
  assign idle_mem = rst & (MEM_R_EN_IN | MEM_W_EN_IN);
  assign pass     = (state_q == IDLE) & ~idle_mem;
  assign done     = (state_q == DONE);

  mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != WAIT),
    .en      ((state_q == WAIT) & ~mem_ack),
    .timeout (wd_to)
  );

  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    we_d    = we_q;
    addr_d  = addr_q;
    st_d    = st_q;
    dst_d   = dst_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (idle_mem) begin
        wb_d    = WB_EN_IN;
        rd_d    = MEM_R_EN_IN;
        we_d    = MEM_W_EN_IN & ~MEM_R_EN_IN;
        addr_d  = ALUResIn;
        st_d    = STValIn;
        dst_d   = destIn;
        rdat_d  = '0;
        state_d = WAIT;
      end
      WAIT: if (mem_ack) begin
        if (rd_q) rdat_d = mem_rdata;
        state_d = DONE;
      end else if (wd_to) begin
        err_d = 1'b1;
        if (rd_q) rdat_d = ERR_DATA;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      st_q    <= '0;
      rdat_q  <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      req_q   <= req_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      st_q    <= st_d;
      rdat_q  <= rdat_d;
      dst_q   <= dst_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = st_q;
  assign mem_err    = err_q;
  assign freeze     = ((state_q == IDLE) & idle_mem) | (state_q == WAIT);
  assign WB_EN      = pass ? WB_EN_IN    : (done ? wb_q   : 1'b0);
  assign MEM_R_EN   = pass ? MEM_R_EN_IN : (done ? rd_q   : 1'b0);
  assign ALURes     = pass ? ALUResIn    : (done ? addr_q : 32'd0);
  assign dest       = pass ? destIn      : (done ? dst_q  : '0);
  assign memReadVal = done ? rdat_q : 32'd0;
endmodule
